addr_fifo_sequencer: RTL and testbench

Programmed address-stream scheduler that feeds the test-vector address FIFO. Software loads a base address, stride, vector count and loop count, then pulses start. The block issues one address per cycle into the address FIFO under almost-full back-pressure, repeating the pass for the programmed loop count. It then waits for both the address and vector FIFOs to drain and signals program end to the driver control and monitor logic.

---
 rtl/addr_fifo_sequencer.sv | 173 +++++++++++++++++
 tb/tb_addr_fifo_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_fifo_sequencer.sv
// Address-stream scheduler: issues base + k*stride for a programmed number of
// passes into the address FIFO, then waits for the FIFOs to drain and flags program end.
module addr_fifo_sequencer #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  addr_stride_i,
    input  logic [CNT_W-1:0]  vector_count_i,
    input  logic [CNT_W-1:0]  loop_count_i,
    input  logic              addr_fifo_almost_full_i,
    input  logic              addr_fifo_full_i,
    input  logic              addr_fifo_empty_i,
    input  logic              vector_fifo_empty_i,
    output logic [ADDR_W-1:0] addr_fifo_din_o,
    output logic              addr_fifo_wr_o,
    output logic              run_program_o,
    output logic              active_program_o,
    output logic              end_program_o,
    output logic              aborted_o,
    output logic [31:0]       issued_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  vec_left_q, vec_left_d;
    logic [CNT_W-1:0]  loops_left_q, loops_left_d;
    logic [ADDR_W-1:0] din_q, din_d;
    logic              wr_q, wr_d;
    logic              run_q, run_d;
    logic              active_q, active_d;
    logic              end_q, end_d;
    logic              aborted_q, aborted_d;
    logic [31:0]       issued_q, issued_d;
    logic              can_issue;

    assign can_issue = !addr_fifo_almost_full_i && !addr_fifo_full_i && !abort_i;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        stride_d     = stride_q;
        cur_addr_d   = cur_addr_q;
        count_d      = count_q;
        vec_left_d   = vec_left_q;
        loops_left_d = loops_left_q;
        din_d        = din_q;
        wr_d         = 1'b0;
        end_d        = 1'b0;
        aborted_d    = aborted_q;
        issued_d     = issued_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d       = base_addr_i;
                    stride_d     = ADDR_W'(addr_stride_i);
                    count_d      = vector_count_i;
                    cur_addr_d   = base_addr_i;
                    vec_left_d   = vector_count_i;
                    loops_left_d = loop_count_i;
                    issued_d     = 32'd0;
                    aborted_d    = 1'b0;
                    if (vector_count_i == '0 || loop_count_i == '0) begin
                        state_d = S_DONE;
                        end_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (abort_i) begin
                    state_d   = S_IDLE;
                    end_d     = 1'b1;
                    aborted_d = 1'b1;
                end else if (can_issue) begin
                    din_d      = cur_addr_q;
                    wr_d       = 1'b1;
                    cur_addr_d = cur_addr_q + stride_q;
                    vec_left_d = vec_left_q - CNT_W'(1);
                    issued_d   = issued_q + 32'd1;
                    // Last address of a pass: rewind immediately so passes stay back-to-back.
                    if (vec_left_q == CNT_W'(1)) begin
                        if (loops_left_q > CNT_W'(1)) begin
                            cur_addr_d   = base_q;
                            vec_left_d   = count_q;
                            loops_left_d = loops_left_q - CNT_W'(1);
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_d   = S_IDLE;
                    end_d     = 1'b1;
                    aborted_d = 1'b1;
                end else if (addr_fifo_empty_i && vector_fifo_empty_i && !wr_q) begin
                    state_d = S_DONE;
                    end_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        run_d    = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            stride_q     <= '0;
            cur_addr_q   <= '0;
            count_q      <= '0;
            vec_left_q   <= '0;
            loops_left_q <= '0;
            din_q        <= '0;
            wr_q         <= 1'b0;
            run_q        <= 1'b0;
            active_q     <= 1'b0;
            end_q        <= 1'b0;
            aborted_q    <= 1'b0;
            issued_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            cur_addr_q   <= cur_addr_d;
            count_q      <= count_d;
            vec_left_q   <= vec_left_d;
            loops_left_q <= loops_left_d;
            din_q        <= din_d;
            wr_q         <= wr_d;
            run_q        <= run_d;
            active_q     <= active_d;
            end_q        <= end_d;
            aborted_q    <= aborted_d;
            issued_q     <= issued_d;
        end
    end

    assign addr_fifo_din_o  = din_q;
    assign addr_fifo_wr_o   = wr_q;
    assign run_program_o    = run_q;
    assign active_program_o = active_q;
    assign end_program_o    = end_q;
    assign aborted_o        = aborted_q;
    assign issued_cnt_o     = issued_q;

endmodule

// File: tb/tb_addr_fifo_sequencer.sv
// Bench for addr_fifo_sequencer: directed programs plus randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_addr_fifo_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [31:0] base_addr;
    logic [15:0] addr_stride, vector_count, loop_count;
    logic        af, full, a_empty, v_empty;
    logic [31:0] din;
    logic        wr, run_p, act_p, end_p, abt;
    logic [31:0] icnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int          ph;          // 0 no program, 1 running (issuing or draining), 2 end pulse
    logic [31:0] m_q[$];      // addresses still to be written
    logic [31:0] m_din;
    logic        m_wr, m_end, m_abt;
    logic [31:0] m_cnt;

    logic [31:0] obs_q[$];
    int          obs_cyc[$];
    int          cyc = 0;
    int          end_seen = 0;

    addr_fifo_sequencer #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .start_i                 (start),
        .abort_i                 (abort),
        .base_addr_i             (base_addr),
        .addr_stride_i           (addr_stride),
        .vector_count_i          (vector_count),
        .loop_count_i            (loop_count),
        .addr_fifo_almost_full_i (af),
        .addr_fifo_full_i        (full),
        .addr_fifo_empty_i       (a_empty),
        .vector_fifo_empty_i     (v_empty),
        .addr_fifo_din_o         (din),
        .addr_fifo_wr_o          (wr),
        .run_program_o           (run_p),
        .active_program_o        (act_p),
        .end_program_o           (end_p),
        .aborted_o               (abt),
        .issued_cnt_o            (icnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        ph = 0;
        m_q.delete();
        m_din = '0;
        m_wr  = 1'b0;
        m_end = 1'b0;
        m_abt = 1'b0;
        m_cnt = '0;
    endtask

    task automatic check_outputs();
        chk("wr",  wr,    m_wr);
        chk("din", din,   m_din);
        chk("run", run_p, ph == 1);
        chk("act", act_p, ph != 0);
        chk("end", end_p, m_end);
        chk("abt", abt,   m_abt);
        chk("cnt", icnt,  m_cnt);
    endtask

    // Apply the current inputs for one clock and check the registered outputs after the edge.
    task automatic cycle();
        logic        n_wr, n_end;
        logic [31:0] n_din;
        n_wr  = 1'b0;
        n_end = 1'b0;
        n_din = m_din;
        case (ph)
            0: if (start) begin
                m_abt = 1'b0;
                m_cnt = '0;
                m_q.delete();
                for (int l = 0; l < int'(loop_count); l++)
                    for (int v = 0; v < int'(vector_count); v++)
                        m_q.push_back(base_addr + 32'(v) * 32'(addr_stride));
                if (m_q.size() == 0) begin
                    ph    = 2;
                    n_end = 1'b1;
                end else begin
                    ph = 1;
                end
            end
            1: if (abort) begin
                ph    = 0;
                n_end = 1'b1;
                m_abt = 1'b1;
                m_q.delete();
            end else if (m_q.size() != 0) begin
                if (!af && !full) begin
                    n_wr  = 1'b1;
                    n_din = m_q.pop_front();
                    m_cnt = m_cnt + 32'd1;
                end
            end else if (a_empty && v_empty && !m_wr) begin
                ph    = 2;
                n_end = 1'b1;
            end
            default: ph = 0;
        endcase
        m_wr  = n_wr;
        m_end = n_end;
        m_din = n_din;

        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (wr) begin
            obs_q.push_back(din);
            obs_cyc.push_back(cyc);
        end
        if (end_p) end_seen++;
    endtask

    task automatic quiet_inputs();
        start = 1'b0; abort = 1'b0; af = 1'b0; full = 1'b0;
        a_empty = 1'b0; v_empty = 1'b0;
    endtask

    task automatic launch(input logic [31:0] b, input logic [15:0] s, input logic [15:0] n, input logic [15:0] l);
        base_addr = b; addr_stride = s; vector_count = n; loop_count = l;
        start = 1'b1;
        cycle();
        start = 1'b0;
        base_addr = $urandom; addr_stride = 16'($urandom); vector_count = 16'($urandom); loop_count = 16'($urandom);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        end_seen = 0;
    endtask

    initial begin
        logic [31:0] exp_loop [6];
        logic [31:0] exp_wrap [3];
        logic [31:0] exp_basic[4];
        int          hit;

        exp_basic = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        exp_loop  = '{32'h20, 32'h28, 32'h30, 32'h20, 32'h28, 32'h30};
        exp_wrap  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

        quiet_inputs();
        base_addr = '0; addr_stride = '0; vector_count = '0; loop_count = '0;
        rst_n = 1'b0;
        model_clear();
        #23;
        check_outputs();
        rst_n = 1'b1;
        repeat (2) cycle();

        // basic pass
        clear_obs();
        launch(32'h1000, 16'd4, 16'd4, 16'd1);
        repeat (6) cycle();
        a_empty = 1'b1; v_empty = 1'b1;
        repeat (3) cycle();
        chk("basic_nwr", obs_q.size(), 4);
        for (int k = 0; k < 4 && k < obs_q.size(); k++) chk("basic_din", obs_q[k], exp_basic[k]);
        if (obs_cyc.size() == 4) chk("basic_consec", obs_cyc[3] - obs_cyc[0], 3);
        chk("basic_cnt", icnt, 32'd4);
        chk("basic_endpulses", end_seen, 1);

        // looping, passes back to back
        clear_obs();
        launch(32'h20, 16'd8, 16'd3, 16'd2);
        repeat (10) cycle();
        chk("loop_nwr", obs_q.size(), 6);
        for (int k = 0; k < 6 && k < obs_q.size(); k++) chk("loop_din", obs_q[k], exp_loop[k]);
        if (obs_cyc.size() == 6) chk("loop_nogap", obs_cyc[5] - obs_cyc[0], 5);
        chk("loop_cnt", icnt, 32'd6);

        // back-pressure in ISSUE cycles 3..7
        clear_obs();
        a_empty = 1'b0; v_empty = 1'b0;
        launch(32'h100, 16'd1, 16'd10, 16'd1);
        for (int i = 1; i <= 20; i++) begin
            af = (i >= 3 && i <= 7);
            if (i > 16) begin a_empty = 1'b1; v_empty = 1'b1; end
            cycle();
        end
        af = 1'b0;
        chk("bp_nwr", obs_q.size(), 10);
        for (int k = 0; k < 10 && k < obs_q.size(); k++) chk("bp_din", obs_q[k], 32'h100 + 32'(k));
        hit = 0;
        foreach (obs_cyc[k]) if (obs_cyc[k] - obs_cyc[0] >= 2 && obs_cyc[k] - obs_cyc[0] <= 6) hit++;
        chk("bp_gap", hit, 0);
        chk("bp_endpulses", end_seen, 1);

        // zero-length program
        clear_obs();
        launch(32'h55, 16'd4, 16'd0, 16'd5);
        chk("zero_end", end_p, 1'b1);
        chk("zero_run", run_p, 1'b0);
        repeat (3) cycle();
        chk("zero_nwr", obs_q.size(), 0);
        chk("zero_endpulses", end_seen, 1);

        // abort after the third write, with address wrap
        clear_obs();
        a_empty = 1'b0; v_empty = 1'b0;
        launch(32'hFFFF_FFF8, 16'd4, 16'd8, 16'd1);
        for (int i = 0; i < 20 && obs_q.size() < 3; i++) cycle();
        chk("abort_reach", obs_q.size(), 3);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_end", end_p, 1'b1);
        chk("abort_flag", abt, 1'b1);
        chk("abort_act", act_p, 1'b0);
        repeat (5) cycle();
        chk("abort_nwr", obs_q.size(), 3);
        for (int k = 0; k < 3 && k < obs_q.size(); k++) chk("abort_din", obs_q[k], exp_wrap[k]);
        chk("abort_sticky", abt, 1'b1);

        // asynchronous reset in the middle of ISSUE, then a fresh program
        launch(32'h40, 16'd4, 16'd6, 16'd1);
        repeat (2) cycle();
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        a_empty = 1'b1; v_empty = 1'b1;
        launch(32'h1000, 16'd4, 16'd4, 16'd1);
        repeat (8) cycle();
        chk("rst_nwr", obs_q.size(), 4);
        for (int k = 0; k < 4 && k < obs_q.size(); k++) chk("rst_din", obs_q[k], exp_basic[k]);
        chk("rst_endpulses", end_seen, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start       = ($urandom_range(0, 7) == 0);
            abort       = ($urandom_range(0, 59) == 0);
            af          = ($urandom_range(0, 3) == 0);
            full        = ($urandom_range(0, 9) == 0);
            a_empty     = ($urandom_range(0, 2) != 0);
            v_empty     = ($urandom_range(0, 2) != 0);
            base_addr   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            addr_stride = 16'($urandom);
            vector_count = 16'($urandom_range(0, 5));
            loop_count  = 16'($urandom_range(0, 3));
            cycle();
        end
        quiet_inputs();
        a_empty = 1'b1; v_empty = 1'b1;
        repeat (60) cycle();
        chk("final_idle", act_p, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
